// File: rtl/norm_pp.sv
// norm_pp: normalizer at the output end of the MAC alignment/accumulation
// datapath. It takes a two's-complement aligned sum together with the
// exponent it was aligned to and produces a sign/magnitude result: the
// leading one becomes the hidden bit, the fraction is left-justified and
// the exponent is re-derived. Zero, underflow (flush to zero) and overflow
// (saturate) are flagged.
//
// Pipeline: S1 magnitude, S2 leading-one detect + exponent, S3 shift/pack
// into the output registers. Latency is 3 cycles absent stalls.
//
// Optional feature: define NORM_RNE_EN to round to nearest-even in S3.
// Without it the bits below the fraction are truncated.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      synchronous active-high reset
//   i_sum      accumulated aligned sum, two's complement [SUM_W]
//   i_max_exp  exponent the sum was aligned to [EXP_W]
//   i_valid    input beat valid
//   o_ready    pipeline can accept a beat this cycle
//   o_valid    output beat valid
//   i_ready    downstream accepts the output beat
//   o_sign     result sign
//   o_exp      normalized exponent [EXP_W]
//   o_frac     fraction bits below the leading one [FRAC_W]
//   o_zero     result is zero (true zero or flushed)
//   o_ovf      exponent overflow, result saturated
//   o_unf      exponent underflow, result flushed to zero
//
// Handshake: a beat enters when i_valid & o_ready and leaves when
// o_valid & i_ready. The whole pipe advances together (adv) whenever the
// output register is empty or being drained; otherwise every stage holds,
// so o_valid and the output data stay stable until i_ready.
module norm_pp #(
  parameter int SUM_W  = 18,
  parameter int LD_POS = 13,
  parameter int EXP_W  = 6,
  parameter int FRAC_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [SUM_W-1:0]  i_sum,
  input  logic [EXP_W-1:0]  i_max_exp,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_sign,
  output logic [EXP_W-1:0]  o_exp,
  output logic [FRAC_W-1:0] o_frac,
  output logic              o_zero,
  output logic              o_ovf,
  output logic              o_unf
);

  localparam int PW = $clog2(SUM_W);
  // Exponent arithmetic width: two extra bits hold a sign and a carry so
  // both underflow and overflow are visible.
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] MAX_E = EW'((1 << EXP_W) - 1);

  logic adv;

  // S1 registers
  logic             v1_q, v1_d;
  logic             sign1_q, sign1_d;
  logic [SUM_W-1:0] mag1_q, mag1_d;
  logic [EXP_W-1:0] mexp1_q, mexp1_d;

  // S2 registers
  logic             v2_q, v2_d;
  logic             sign2_q, sign2_d;
  logic             zero2_q, zero2_d;
  logic [SUM_W-1:0] mag2_q, mag2_d;
  logic [PW-1:0]    p2_q, p2_d;
  logic [EW-1:0]    e2_q, e2_d;

  // S3 / output registers
  logic              v3_q, v3_d;
  logic              sign3_q, sign3_d;
  logic [EXP_W-1:0]  exp3_q, exp3_d;
  logic [FRAC_W-1:0] frac3_q, frac3_d;
  logic              zero3_q, zero3_d;
  logic              ovf3_q, ovf3_d;
  logic              unf3_q, unf3_d;

  // S3 working signals
  logic [PW-1:0]     sh;
  logic [FRAC_W-1:0] frac_t;
  logic [EW-1:0]     e_t;
`ifdef NORM_RNE_EN
  logic [SUM_W-2:0]  mant_lo;
  logic [FRAC_W:0]   frac_inc;
  logic              guard;
  logic              sticky;
`endif

  assign adv     = !v3_q | i_ready;
  assign o_ready = adv;

  // S1: magnitude. Held in SUM_W unsigned bits so the most-negative sum
  // negates to 2^(SUM_W-1) without wrapping.
  always_comb begin
    v1_d    = i_valid;
    sign1_d = i_sum[SUM_W-1];
    mag1_d  = i_sum[SUM_W-1] ? (~i_sum + SUM_W'(1)) : i_sum;
    mexp1_d = i_max_exp;
  end

  // S2: leading-one detect. Ascending scan so the highest set bit wins.
  always_comb begin
    v2_d    = v1_q;
    sign2_d = sign1_q;
    mag2_d  = mag1_q;
    zero2_d = (mag1_q == '0);
    p2_d    = '0;
    for (int i = 0; i < SUM_W; i++) begin
      if (mag1_q[i]) p2_d = PW'(i);
    end
    // Modular arithmetic gives the correct two's-complement result in EW bits.
    e2_d = EW'(mexp1_q) + EW'(p2_d) - EW'(LD_POS);
  end

  // S3: left-justify, optional rounding, special cases.
  always_comb begin
    v3_d    = v2_q;
    sign3_d = sign2_q;
    exp3_d  = '0;
    frac3_d = '0;
    zero3_d = 1'b0;
    ovf3_d  = 1'b0;
    unf3_d  = 1'b0;
    sh      = PW'(SUM_W - 1) - p2_q;
    e_t     = e2_q;
`ifdef NORM_RNE_EN
    // Hidden bit dropped; the rest feeds fraction, guard and sticky.
    mant_lo  = (SUM_W-1)'(mag2_q << sh);
    frac_t   = mant_lo[SUM_W-2 -: FRAC_W];
    guard    = mant_lo[SUM_W-2-FRAC_W];
    sticky   = |mant_lo[SUM_W-3-FRAC_W:0];
    frac_inc = {1'b0, frac_t} + (FRAC_W+1)'(1);
    if (guard & (sticky | frac_t[0])) begin
      frac_t = frac_inc[FRAC_W-1:0];
      // 1.111 rounding to 10.000: fraction wraps to 0, exponent steps up.
      if (frac_inc[FRAC_W]) e_t = e2_q + EW'(1);
    end
`else
    frac_t = FRAC_W'((mag2_q << sh) >> (SUM_W - 1 - FRAC_W));
`endif
    if (zero2_q) begin
      sign3_d = 1'b0;
      zero3_d = 1'b1;
    end else if (e_t[EW-1]) begin
      unf3_d  = 1'b1;
      zero3_d = 1'b1;
    end else if (e_t > MAX_E) begin
      ovf3_d  = 1'b1;
      exp3_d  = '1;
      frac3_d = '1;
    end else begin
      exp3_d  = e_t[EXP_W-1:0];
      frac3_d = frac_t;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      mag1_q  <= '0;
      mexp1_q <= '0;
      v2_q    <= 1'b0;
      sign2_q <= 1'b0;
      zero2_q <= 1'b0;
      mag2_q  <= '0;
      p2_q    <= '0;
      e2_q    <= '0;
      v3_q    <= 1'b0;
      sign3_q <= 1'b0;
      exp3_q  <= '0;
      frac3_q <= '0;
      zero3_q <= 1'b0;
      ovf3_q  <= 1'b0;
      unf3_q  <= 1'b0;
    end else if (adv) begin
      v1_q    <= v1_d;
      sign1_q <= sign1_d;
      mag1_q  <= mag1_d;
      mexp1_q <= mexp1_d;
      v2_q    <= v2_d;
      sign2_q <= sign2_d;
      zero2_q <= zero2_d;
      mag2_q  <= mag2_d;
      p2_q    <= p2_d;
      e2_q    <= e2_d;
      v3_q    <= v3_d;
      sign3_q <= sign3_d;
      exp3_q  <= exp3_d;
      frac3_q <= frac3_d;
      zero3_q <= zero3_d;
      ovf3_q  <= ovf3_d;
      unf3_q  <= unf3_d;
    end
  end

  assign o_valid = v3_q;
  assign o_sign  = sign3_q;
  assign o_exp   = exp3_q;
  assign o_frac  = frac3_q;
  assign o_zero  = zero3_q;
  assign o_ovf   = ovf3_q;
  assign o_unf   = unf3_q;

endmodule
